// File: rtl/mem_wb_stage.sv
// RV64 memory-access stage fused with the MEM/WB pipeline register.
// Doubleword loads/stores against an internal data memory; result registered for write-back.
module mem_wb_stage #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic [63:0] alu_result,
  input  logic [63:0] rs2_data,
  input  logic        ld_sd_sel,
  input  logic [63:0] wb_fwd_data,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_alu_result,
  output logic [63:0] wb_mem_data,
  output logic        wb_fault
);

  logic [63:0] mem_q [DEPTH];

  logic [63:0] st_data;
  logic [63:0] ld_data;
  logic [AW-1:0] idx;
  logic        legal;
  logic        fault;
  logic        mem_we;

  logic        wb_reg_write_q,  wb_reg_write_d;
  logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [4:0]  wb_rd_q,         wb_rd_d;
  logic [63:0] wb_alu_result_q, wb_alu_result_d;
  logic [63:0] wb_mem_data_q,   wb_mem_data_d;
  logic        wb_fault_q,      wb_fault_d;

  // Address decode, fault detection and store-data source select
  always_comb begin
    st_data = ld_sd_sel ? wb_fwd_data : rs2_data;
    idx     = alu_result[AW+2:3];
    legal   = (alu_result[2:0] == 3'b000) && (alu_result[63:AW+3] == '0);
    fault   = (mem_read || mem_write) && (!legal || (mem_read && mem_write));
    mem_we  = mem_write && !fault && !stall && !flush && rst_n;
    ld_data = mem_q[idx];
  end

  // Data memory is intentionally not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx] <= st_data;
  end

  // MEM/WB next state: flush beats stall beats normal capture
  always_comb begin
    wb_reg_write_d  = wb_reg_write_q;
    wb_mem_to_reg_d = wb_mem_to_reg_q;
    wb_rd_d         = wb_rd_q;
    wb_alu_result_d = wb_alu_result_q;
    wb_mem_data_d   = wb_mem_data_q;
    wb_fault_d      = wb_fault_q;
    if (flush) begin
      wb_reg_write_d  = 1'b0;
      wb_mem_to_reg_d = 1'b0;
      wb_rd_d         = 5'd0;
      wb_alu_result_d = 64'd0;
      wb_mem_data_d   = 64'd0;
      wb_fault_d      = 1'b0;
    end else if (!stall) begin
      wb_reg_write_d  = reg_write && !fault;
      wb_mem_to_reg_d = mem_to_reg;
      wb_rd_d         = rd;
      wb_alu_result_d = alu_result;
      wb_mem_data_d   = (mem_read && !fault) ? ld_data : 64'd0;
      wb_fault_d      = fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_q         <= 5'd0;
      wb_alu_result_q <= 64'd0;
      wb_mem_data_q   <= 64'd0;
      wb_fault_q      <= 1'b0;
    end else begin
      wb_reg_write_q  <= wb_reg_write_d;
      wb_mem_to_reg_q <= wb_mem_to_reg_d;
      wb_rd_q         <= wb_rd_d;
      wb_alu_result_q <= wb_alu_result_d;
      wb_mem_data_q   <= wb_mem_data_d;
      wb_fault_q      <= wb_fault_d;
    end
  end

  assign wb_reg_write  = wb_reg_write_q;
  assign wb_mem_to_reg = wb_mem_to_reg_q;
  assign wb_rd         = wb_rd_q;
  assign wb_alu_result = wb_alu_result_q;
  assign wb_mem_data   = wb_mem_data_q;
  assign wb_fault      = wb_fault_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall, flush, mem_read, mem_write, mem_to_reg, reg_write, ld_sd_sel;
  logic [4:0]  rd;
  logic [63:0] alu_result, rs2_data, wb_fwd_data;
  logic        wb_reg_write, wb_mem_to_reg, wb_fault;
  logic [4:0]  wb_rd;
  logic [63:0] wb_alu_result, wb_mem_data;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.DEPTH(1024), .AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .rd(rd), .alu_result(alu_result),
    .rs2_data(rs2_data), .ld_sd_sel(ld_sd_sel), .wb_fwd_data(wb_fwd_data),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd),
    .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_fault(wb_fault)
  );

  always #5 clk = ~clk;

  // Present one EX/MEM bundle: rd_en, wr_en, m2r, rw, rd, addr, rs2, sel, fwd, stall, flush
  task automatic drive(input logic r_en, input logic w_en, input logic m2r, input logic rw,
                       input logic [4:0] r, input logic [63:0] a, input logic [63:0] d,
                       input logic sel, input logic [63:0] fwd, input logic st, input logic fl);
    mem_read = r_en; mem_write = w_en; mem_to_reg = m2r; reg_write = rw;
    rd = r; alu_result = a; rs2_data = d; ld_sd_sel = sel; wb_fwd_data = fwd;
    stall = st; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 0, 64'd0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
          {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom}, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data, wb_fault} !== '0) begin
      errors++; $display("FAIL reset_async: got rd=%0d alu=%h data=%h rw=%b", wb_rd, wb_alu_result, wb_mem_data, wb_reg_write);
    end
    step(); step();
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data, wb_fault} !== '0) begin
      errors++; $display("FAIL reset_held: got rd=%0d alu=%h data=%h", wb_rd, wb_alu_result, wb_mem_data);
    end
    idle();
    @(negedge clk) rst_n = 1'b1;
    step(); step();
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data, wb_fault} !== '0) begin
      errors++; $display("FAIL reset_release: got rd=%0d alu=%h data=%h", wb_rd, wb_alu_result, wb_mem_data);
    end
  endtask

  task automatic test_store_load();
    drive(0, 1, 0, 0, 5'd0, 64'h18, 64'hDEADBEEF_CAFEF00D, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_fault !== 1'b0 || wb_mem_data !== 64'd0 || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL store_wb: got fault=%b data=%h rw=%b exp 0 0 0", wb_fault, wb_mem_data, wb_reg_write);
    end
    drive(1, 0, 1, 1, 5'd5, 64'h18, 64'h0, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_mem_data !== 64'hDEADBEEF_CAFEF00D) begin
      errors++; $display("FAIL load_data: got %h exp deadbeefcafef00d", wb_mem_data);
    end
    checks++;
    if (wb_reg_write !== 1'b1 || wb_mem_to_reg !== 1'b1 || wb_rd !== 5'd5 || wb_fault !== 1'b0) begin
      errors++; $display("FAIL load_ctrl: got rw=%b m2r=%b rd=%0d fault=%b exp 1 1 5 0", wb_reg_write, wb_mem_to_reg, wb_rd, wb_fault);
    end
  endtask

  task automatic test_forwarding();
    drive(0, 1, 0, 0, 5'd0, 64'h40, 64'h1111, 1, 64'h2222, 0, 0);
    step();
    drive(1, 0, 1, 1, 5'd6, 64'h40, 64'h0, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_mem_data !== 64'h2222) begin
      errors++; $display("FAIL fwd_store: got %h exp 2222", wb_mem_data);
    end
  endtask

  task automatic test_fault();
    drive(1, 0, 1, 1, 5'd3, 64'h44, 64'h0, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_fault !== 1'b1 || wb_reg_write !== 1'b0 || wb_mem_data !== 64'd0) begin
      errors++; $display("FAIL misalign_load: got fault=%b rw=%b data=%h exp 1 0 0", wb_fault, wb_reg_write, wb_mem_data);
    end
    checks++;
    if (wb_rd !== 5'd3 || wb_alu_result !== 64'h44) begin
      errors++; $display("FAIL fault_payload: got rd=%0d alu=%h exp 3 44", wb_rd, wb_alu_result);
    end
    drive(0, 1, 0, 0, 5'd0, 64'h0, 64'hA5A5_0000_1234_5678, 0, 64'h0, 0, 0);
    step();
    // 0x2000 aliases index 0 if the range check were missing
    drive(0, 1, 0, 0, 5'd0, 64'h2000, 64'hBAD0_BAD0_BAD0_BAD0, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_fault !== 1'b1) begin
      errors++; $display("FAIL range_store: got fault=%b exp 1", wb_fault);
    end
    drive(1, 1, 1, 1, 5'd4, 64'h0, 64'hBAD1_BAD1_BAD1_BAD1, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_fault !== 1'b1 || wb_reg_write !== 1'b0) begin
      errors++; $display("FAIL rd_and_wr: got fault=%b rw=%b exp 1 0", wb_fault, wb_reg_write);
    end
    drive(0, 1, 0, 0, 5'd0, 64'h1, 64'hBAD2_BAD2_BAD2_BAD2, 0, 64'h0, 0, 0);
    step();
    drive(1, 0, 1, 1, 5'd8, 64'h0, 64'h0, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_mem_data !== 64'hA5A5_0000_1234_5678 || wb_fault !== 1'b0) begin
      errors++; $display("FAIL fault_no_write: got %h fault=%b exp a5a5000012345678 0", wb_mem_data, wb_fault);
    end
  endtask

  task automatic test_stall_flush();
    drive(0, 0, 0, 1, 5'd9, 64'h99, 64'h0, 0, 64'h0, 0, 0);
    step();
    drive(0, 1, 0, 0, 5'd1, 64'h18, 64'h1357_9BDF_0000_0001, 0, 64'h0, 1, 0);
    step(); step();
    checks++;
    if (wb_rd !== 5'd9 || wb_alu_result !== 64'h99 || wb_reg_write !== 1'b1 || wb_fault !== 1'b0) begin
      errors++; $display("FAIL stall_hold: got rd=%0d alu=%h rw=%b exp 9 99 1", wb_rd, wb_alu_result, wb_reg_write);
    end
    drive(0, 1, 0, 1, 5'd2, 64'h18, 64'h2468_ACE0_0000_0002, 0, 64'h0, 1, 1);
    step();
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data, wb_fault} !== '0) begin
      errors++; $display("FAIL flush_zero: got rd=%0d alu=%h rw=%b", wb_rd, wb_alu_result, wb_reg_write);
    end
    drive(1, 0, 1, 1, 5'd10, 64'h18, 64'h0, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_mem_data !== 64'hDEADBEEF_CAFEF00D) begin
      errors++; $display("FAIL stall_no_write: got %h exp deadbeefcafef00d", wb_mem_data);
    end
  endtask

  task automatic test_passthrough();
    drive(0, 0, 0, 1, 5'd7, 64'h55, 64'hFFFF, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_rd !== 5'd7 || wb_alu_result !== 64'h55 || wb_mem_data !== 64'd0 ||
        wb_reg_write !== 1'b1 || wb_fault !== 1'b0 || wb_mem_to_reg !== 1'b0) begin
      errors++; $display("FAIL passthrough: got rd=%0d alu=%h data=%h rw=%b fault=%b", wb_rd, wb_alu_result, wb_mem_data, wb_reg_write, wb_fault);
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 0, 0, 5'd0, 64'h1FF8, 64'h0123_4567_89AB_CDEF, 0, 64'h0, 0, 0);
    step();
    drive(0, 1, 0, 0, 5'd0, 64'h1FF8, 64'hFEDC_BA98_7654_3210, 0, 64'h0, 0, 0);
    step();
    drive(1, 0, 1, 1, 5'd11, 64'h1FF8, 64'h0, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_mem_data !== 64'hFEDC_BA98_7654_3210 || wb_fault !== 1'b0) begin
      errors++; $display("FAIL top_index_b2b: got %h fault=%b exp fedcba9876543210 0", wb_mem_data, wb_fault);
    end
  endtask

  task automatic test_reset_mid_stall();
    drive(0, 1, 0, 0, 5'd0, 64'h200, 64'h0F0F_0F0F_0F0F_0F0F, 0, 64'h0, 0, 0);
    step();
    drive(0, 0, 0, 1, 5'd12, 64'h77, 64'h0, 0, 64'h0, 0, 0);
    step();
    drive(0, 1, 0, 1, 5'd13, 64'h200, 64'hDEAD_0000_DEAD_0000, 0, 64'h0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data, wb_fault} !== '0) begin
      errors++; $display("FAIL reset_mid_stall: got rd=%0d alu=%h rw=%b", wb_rd, wb_alu_result, wb_reg_write);
    end
    stall = 1'b0;
    step(); step();
    idle();
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++;
    if ({wb_reg_write, wb_mem_to_reg, wb_rd, wb_alu_result, wb_mem_data, wb_fault} !== '0) begin
      errors++; $display("FAIL resume_bubble: got rd=%0d alu=%h rw=%b", wb_rd, wb_alu_result, wb_reg_write);
    end
    drive(1, 0, 1, 1, 5'd14, 64'h200, 64'h0, 0, 64'h0, 0, 0);
    step();
    checks++;
    if (wb_mem_data !== 64'h0F0F_0F0F_0F0F_0F0F) begin
      errors++; $display("FAIL no_write_in_reset: got %h exp 0f0f0f0f0f0f0f0f", wb_mem_data);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_store_load();
    test_forwarding();
    test_fault();
    test_stall_flush();
    test_passthrough();
    test_back_to_back();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
